video_oam_dma: RTL and testbench
================================

# video_oam_dma

Sprite-attribute DMA engine: the CPU-side stage directly upstream of the video block's host register port. A CPU write to $4014 starts the transfer. The engine halts the CPU, reads 256 bytes from CPU page $XX00–$XXFF, and writes each byte to OAMDATA (register 4) on the video host port. Cycle counts match 2A03 behaviour: 513 or 514 CPU cycles.

## Interface
Parameters:
- P_trigger_addr, 16'h4014, CPU address that starts a transfer
- P_oam_reg, 3'd4, video host register index written per byte (OAMDATA)

Ports:
- I_clock  in  1  system clock (single clock domain)
- I_reset  in  1  reset, asynchronous, active-low
- I_tick  in  1  one-clock strobe marking the last clock of each CPU cycle
- I_cpu_odd  in  1  qualified by I_tick: 1 = the CPU cycle ending now is a put (odd) cycle
- I_cpu_addr  in  16  CPU bus address
- I_cpu_wren  in  1  CPU write enable
- I_cpu_data  in  8  CPU write data (page number)
- O_cpu_halt  out  1  holds the CPU (RDY low) while the engine owns the bus
- O_dma_addr  out  16  DMA read address on the CPU bus
- O_dma_rden  out  1  DMA read strobe
- I_dma_data  in  8  CPU bus read data, sampled on the read tick
- O_ppu_addr  out  3  video host register select
- O_ppu_wren  out  1  video host write enable
- O_ppu_data  out  8  video host write data
- O_busy  out  1  transfer in progress

## Operation
- A tick period is the run of clocks after one I_tick up to and including the next I_tick. Registered outputs change on the clock after an I_tick and hold for the whole period.
- Trigger: on a tick where I_cpu_wren=1 and I_cpu_addr=P_trigger_addr, latch I_cpu_data as the page and go IDLE→HALT.
- States:
  - IDLE: no transfer.
  - HALT: one dummy tick; O_cpu_halt=1.
  - ALIGN: consumes one tick only if the tick following HALT is odd.
  - READ: O_dma_addr={page,idx}, O_dma_rden=1; I_dma_data is latched at the ending I_tick.
  - WRITE: O_ppu_addr=P_oam_reg, O_ppu_wren=1, O_ppu_data=latched byte.
  - After each WRITE, idx increments.
- HALT exit: if the next tick's I_cpu_odd=1 → ALIGN, else → READ.
- ALIGN → READ.
- READ → WRITE.
- WRITE → READ while idx≠8'hFF. WRITE with idx=8'hFF → IDLE.
- idx is 8 bits and starts at 0. The page byte is fixed for the whole transfer, so the address high byte never carries.
- O_ppu_wren is low in every non-WRITE tick. Each byte therefore gives the video regdec a fresh wren rising edge.
- O_cpu_halt and O_busy are 1 in HALT, ALIGN, READ and WRITE; 0 in IDLE.
- When not in READ: O_dma_rden=0 and O_dma_addr=0.
- When not in WRITE: O_ppu_wren=0; O_ppu_addr and O_ppu_data hold their last values.
- Trigger writes arriving while O_busy=1 are ignored; the page is not relatched.
- A trigger and transfer completion in the same tick cannot occur, because the CPU is halted.

## Timing
- Reset value of every output: O_cpu_halt=0, O_busy=0, O_dma_rden=0, O_ppu_wren=0, O_dma_addr=16'h0000, O_ppu_addr=3'd0, O_ppu_data=8'h00.
- Reset clears page, idx and the byte latch, and returns the engine to IDLE.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); the CPU is released.
- Trigger tick n:
  - O_cpu_halt and O_busy rise on the clock after tick n.
  - Even alignment: reads at ticks n+2, n+4, … n+512; writes at n+3 … n+513; O_cpu_halt falls on the clock after tick n+513. Total 513 halted cycles.
  - Odd alignment: ALIGN at n+2; reads n+3 … n+513; writes n+4 … n+514; total 514 halted cycles.
- Read-to-write latency: a byte sampled at the end of a READ tick is on O_ppu_data throughout the immediately following WRITE tick.
- Between ticks the FSM state is frozen. Non-tick clocks never change state or outputs.

## Test plan
- Even-aligned transfer of page $02, memory model returning (addr & 8'hFF) ^ 8'hA5:
  - 256 OAMDATA writes with data k^8'hA5 for k=0..255, in order.
  - O_cpu_halt high for exactly 513 ticks.
  - Read addresses $0200..$02FF.
- Same transfer with the tick after HALT odd: ALIGN occurs, O_cpu_halt high for 514 ticks, data sequence identical.
- Page $FF: addresses $FF00..$FFFF; no wrap into $0000.
- Second $4014 write (page $03) issued at tick n+100 of an active transfer: ignored; all reads stay on page $02; no restart.
- I_reset low at tick n+300, mid-transfer:
  - All outputs at reset values within the same clock.
  - After release, no OAM writes occur until a new trigger.
  - A new trigger with $07 transfers page $07 from idx 0.
- I_tick held high every clock versus one clock in 12: identical tick-count results; O_ppu_wren is 0 between consecutive WRITE ticks (256 distinct rising edges).

Source files
------------

// File: rtl/video_oam_dma.sv
// rtl/video_oam_dma.sv - sprite-attribute DMA: halts the CPU, copies one 256-byte page to OAMDATA
module video_oam_dma #(
  parameter logic [15:0] P_trigger_addr = 16'h4014,
  parameter logic [2:0]  P_oam_reg      = 3'd4
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_cpu_odd,
  input  logic [15:0] I_cpu_addr,
  input  logic        I_cpu_wren,
  input  logic [7:0]  I_cpu_data,
  output logic        O_cpu_halt,
  output logic [15:0] O_dma_addr,
  output logic        O_dma_rden,
  input  logic [7:0]  I_dma_data,
  output logic [2:0]  O_ppu_addr,
  output logic        O_ppu_wren,
  output logic [7:0]  O_ppu_data,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_q;
  logic [2:0]  ppu_addr_q;
  logic        trig_hit;

  // A CPU write to the trigger address; only acted on at a tick while idle
  assign trig_hit = I_cpu_wren && (I_cpu_addr == P_trigger_addr);

  // State register; the state only ever moves at a tick
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; frozen on non-tick clocks
  always_comb begin
    state_nxt = state;
    if (I_tick) begin
      case (state)
        S_IDLE:  if (trig_hit) state_nxt = S_HALT;
        S_HALT:  state_nxt = I_cpu_odd ? S_ALIGN : S_READ;
        S_ALIGN: state_nxt = S_READ;
        S_READ:  state_nxt = S_WRITE;
        S_WRITE: state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Page, byte index, read-data latch and host register select
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      page       <= 8'h00;
      idx        <= 8'h00;
      data_q     <= 8'h00;
      ppu_addr_q <= 3'd0;
    end else if (I_tick) begin
      case (state)
        S_IDLE: begin
          if (trig_hit) begin
            page <= I_cpu_data;
            idx  <= 8'h00;
          end
        end
        S_READ: begin
          data_q     <= I_dma_data;
          ppu_addr_q <= P_oam_reg;
        end
        S_WRITE: idx <= idx + 8'h01;
        default: ;
      endcase
    end
  end

  // Output decode from the registered state, so outputs hold for a whole tick period
  always_comb begin
    O_cpu_halt = 1'b0;
    O_busy     = 1'b0;
    O_dma_rden = 1'b0;
    O_dma_addr = 16'h0000;
    O_ppu_wren = 1'b0;
    O_ppu_addr = ppu_addr_q;
    O_ppu_data = data_q;
    if (state != S_IDLE) begin
      O_cpu_halt = 1'b1;
      O_busy     = 1'b1;
    end
    if (state == S_READ) begin
      O_dma_rden = 1'b1;
      O_dma_addr = {page, idx};
    end
    if (state == S_WRITE) begin
      O_ppu_wren = 1'b1;
    end
  end

endmodule

// File: tb/tb_video_oam_dma.sv
// tb/tb_video_oam_dma.sv - directed bench for video_oam_dma
module tb_video_oam_dma;

  logic        I_clock;
  logic        I_reset;
  logic        I_tick;
  logic        I_cpu_odd;
  logic [15:0] I_cpu_addr;
  logic        I_cpu_wren;
  logic [7:0]  I_cpu_data;
  logic        O_cpu_halt;
  logic [15:0] O_dma_addr;
  logic        O_dma_rden;
  logic [7:0]  I_dma_data;
  logic [2:0]  O_ppu_addr;
  logic        O_ppu_wren;
  logic [7:0]  O_ppu_data;
  logic        O_busy;

  int checks;
  int errors;
  int per;
  int rises;
  int unstable;
  logic prev_wren;

  logic        obs_halt;
  logic        obs_rden;
  logic        obs_wren;
  logic [15:0] obs_addr;
  logic [2:0]  obs_paddr;
  logic [7:0]  obs_pdata;
  logic [15:0] last_addr;

  video_oam_dma dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_tick     (I_tick),
    .I_cpu_odd  (I_cpu_odd),
    .I_cpu_addr (I_cpu_addr),
    .I_cpu_wren (I_cpu_wren),
    .I_cpu_data (I_cpu_data),
    .O_cpu_halt (O_cpu_halt),
    .O_dma_addr (O_dma_addr),
    .O_dma_rden (O_dma_rden),
    .I_dma_data (I_dma_data),
    .O_ppu_addr (O_ppu_addr),
    .O_ppu_wren (O_ppu_wren),
    .O_ppu_data (O_ppu_data),
    .O_busy     (O_busy)
  );

  // CPU memory model
  assign I_dma_data = O_dma_addr[7:0] ^ 8'hA5;

  initial I_clock = 1'b0;
  always #5 I_clock = ~I_clock;

  // One tick period of per clocks; samples outputs mid-clock and tracks stability and wren edges
  task automatic run_tick();
    logic [30:0] snap;
    logic [30:0] cur;
    snap = '0;
    for (int c = 0; c < per; c++) begin
      I_tick = (c == per - 1);
      @(negedge I_clock);
      cur = {O_cpu_halt, O_busy, O_dma_rden, O_ppu_wren, O_dma_addr, O_ppu_addr, O_ppu_data};
      if (c == 0) snap = cur;
      else if (cur !== snap) unstable++;
      if (O_ppu_wren && !prev_wren) rises++;
      prev_wren = O_ppu_wren;
      if (c == per - 1) begin
        obs_halt  = O_cpu_halt;
        obs_rden  = O_dma_rden;
        obs_wren  = O_ppu_wren;
        obs_addr  = O_dma_addr;
        obs_paddr = O_ppu_addr;
        obs_pdata = O_ppu_data;
      end
      @(posedge I_clock);
      #1;
    end
    I_tick = 1'b0;
  endtask

  task automatic transfer(input logic [7:0] pg, input logic odd, input logic retrig,
                          output int halt_ticks, output int nreads, output int nwrites,
                          output int dummy, output int data_errs, output int addr_errs,
                          output int nrises);
    logic [7:0] ridx;
    logic [7:0] widx;
    int r0;
    bit done;
    halt_ticks = 0; nreads = 0; nwrites = 0; dummy = 0;
    data_errs = 0; addr_errs = 0; ridx = 8'h00; widx = 8'h00; done = 0;
    r0 = rises;
    I_cpu_odd  = odd;
    I_cpu_wren = 1'b1;
    I_cpu_addr = 16'h4014;
    I_cpu_data = pg;
    run_tick();
    I_cpu_wren = 1'b0;
    I_cpu_addr = 16'h0000;
    for (int t = 1; t < 600; t++) begin
      if (retrig && t == 100) begin
        I_cpu_wren = 1'b1;
        I_cpu_addr = 16'h4014;
        I_cpu_data = 8'h03;
      end
      run_tick();
      I_cpu_wren = 1'b0;
      I_cpu_addr = 16'h0000;
      if (!obs_halt) begin
        done = 1;
        break;
      end
      halt_ticks++;
      if (!obs_rden && !obs_wren) dummy++;
      if (obs_rden) begin
        if (obs_addr !== {pg, ridx}) addr_errs++;
        last_addr = obs_addr;
        ridx++;
        nreads++;
      end
      if (obs_wren) begin
        if (obs_pdata !== (widx ^ 8'hA5) || obs_paddr !== 3'd4) data_errs++;
        widx++;
        nwrites++;
      end
    end
    nrises = rises - r0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL transfer_timeout page %0h: halt still high after 600 ticks", pg);
    end
  endtask

  task automatic test_reset();
    checks += 7;
    if (O_cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", O_cpu_halt); end
    if (O_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", O_busy); end
    if (O_dma_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", O_dma_rden); end
    if (O_ppu_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", O_ppu_wren); end
    if (O_dma_addr !== 16'h0000) begin errors++; $display("FAIL reset_dma_addr got %h want 0000", O_dma_addr); end
    if (O_ppu_addr !== 3'd0) begin errors++; $display("FAIL reset_ppu_addr got %0d want 0", O_ppu_addr); end
    if (O_ppu_data !== 8'h00) begin errors++; $display("FAIL reset_ppu_data got %h want 00", O_ppu_data); end
  endtask

  task automatic test_even();
    int h, nr, nw, d, de, ae, nri;
    per = 3;
    unstable = 0;
    transfer(8'h02, 1'b0, 1'b0, h, nr, nw, d, de, ae, nri);
    checks += 8;
    if (h !== 513) begin errors++; $display("FAIL even_halt_ticks got %0d want 513", h); end
    if (nr !== 256) begin errors++; $display("FAIL even_reads got %0d want 256", nr); end
    if (nw !== 256) begin errors++; $display("FAIL even_writes got %0d want 256", nw); end
    if (d !== 1) begin errors++; $display("FAIL even_dummy_ticks got %0d want 1", d); end
    if (de !== 0) begin errors++; $display("FAIL even_data_errs got %0d want 0", de); end
    if (ae !== 0) begin errors++; $display("FAIL even_addr_errs got %0d want 0", ae); end
    if (nri !== 256) begin errors++; $display("FAIL even_wren_rises got %0d want 256", nri); end
    if (unstable !== 0) begin errors++; $display("FAIL even_between_ticks got %0d changes want 0", unstable); end
  endtask

  task automatic test_odd();
    int h, nr, nw, d, de, ae, nri;
    per = 2;
    transfer(8'h02, 1'b1, 1'b0, h, nr, nw, d, de, ae, nri);
    I_cpu_odd = 1'b0;
    checks += 4;
    if (h !== 514) begin errors++; $display("FAIL odd_halt_ticks got %0d want 514", h); end
    if (d !== 2) begin errors++; $display("FAIL odd_dummy_ticks got %0d want 2", d); end
    if (nw !== 256) begin errors++; $display("FAIL odd_writes got %0d want 256", nw); end
    if (de !== 0 || ae !== 0) begin errors++; $display("FAIL odd_data_addr_errs got %0d/%0d want 0/0", de, ae); end
  endtask

  task automatic test_page_ff();
    int h, nr, nw, d, de, ae, nri;
    per = 1;
    transfer(8'hFF, 1'b0, 1'b0, h, nr, nw, d, de, ae, nri);
    checks += 3;
    if (ae !== 0) begin errors++; $display("FAIL pageff_addr_errs got %0d want 0", ae); end
    if (last_addr !== 16'hFFFF) begin errors++; $display("FAIL pageff_last_addr got %h want FFFF", last_addr); end
    if (nr !== 256 || h !== 513) begin errors++; $display("FAIL pageff_counts got %0d/%0d want 256/513", nr, h); end
  endtask

  task automatic test_retrigger();
    int h, nr, nw, d, de, ae, nri;
    per = 2;
    transfer(8'h02, 1'b0, 1'b1, h, nr, nw, d, de, ae, nri);
    checks += 3;
    if (ae !== 0) begin errors++; $display("FAIL retrig_addr_errs got %0d want 0", ae); end
    if (h !== 513) begin errors++; $display("FAIL retrig_halt_ticks got %0d want 513", h); end
    if (nw !== 256 || de !== 0) begin errors++; $display("FAIL retrig_writes got %0d errs %0d want 256/0", nw, de); end
  endtask

  task automatic test_reset_mid();
    int h, nr, nw, d, de, ae, nri, r0;
    per = 2;
    I_cpu_odd  = 1'b0;
    I_cpu_wren = 1'b1;
    I_cpu_addr = 16'h4014;
    I_cpu_data = 8'h02;
    run_tick();
    I_cpu_wren = 1'b0;
    I_cpu_addr = 16'h0000;
    for (int t = 1; t < 300; t++) run_tick();
    #2;
    I_reset = 1'b0;
    #1;
    checks += 3;
    if (O_cpu_halt !== 1'b0 || O_busy !== 1'b0) begin errors++; $display("FAIL midreset_halt_busy got %b%b want 00", O_cpu_halt, O_busy); end
    if (O_dma_rden !== 1'b0 || O_ppu_wren !== 1'b0) begin errors++; $display("FAIL midreset_strobes got %b%b want 00", O_dma_rden, O_ppu_wren); end
    if (O_dma_addr !== 16'h0 || O_ppu_addr !== 3'd0 || O_ppu_data !== 8'h0) begin
      errors++; $display("FAIL midreset_buses got %h/%0d/%h want 0000/0/00", O_dma_addr, O_ppu_addr, O_ppu_data);
    end
    @(posedge I_clock);
    #1;
    I_reset = 1'b1;
    prev_wren = 1'b0;
    r0 = rises;
    for (int t = 0; t < 20; t++) run_tick();
    checks += 2;
    if (rises !== r0) begin errors++; $display("FAIL postreset_wren got %0d writes want 0", rises - r0); end
    if (obs_halt !== 1'b0) begin errors++; $display("FAIL postreset_halt got %b want 0", obs_halt); end
    transfer(8'h07, 1'b0, 1'b0, h, nr, nw, d, de, ae, nri);
    checks += 2;
    if (ae !== 0 || nr !== 256) begin errors++; $display("FAIL page07_reads got %0d errs %0d want 256/0", nr, ae); end
    if (de !== 0 || nw !== 256) begin errors++; $display("FAIL page07_writes got %0d errs %0d want 256/0", nw, de); end
  endtask

  task automatic test_tick_rate();
    int h1, h12, nr, nw, d, de, ae, r1, r12;
    per = 1;
    transfer(8'h05, 1'b0, 1'b0, h1, nr, nw, d, de, ae, r1);
    per = 12;
    unstable = 0;
    transfer(8'h05, 1'b0, 1'b0, h12, nr, nw, d, de, ae, r12);
    checks += 5;
    if (h1 !== 513) begin errors++; $display("FAIL rate1_halt_ticks got %0d want 513", h1); end
    if (h12 !== 513) begin errors++; $display("FAIL rate12_halt_ticks got %0d want 513", h12); end
    if (r1 !== 256) begin errors++; $display("FAIL rate1_wren_rises got %0d want 256", r1); end
    if (r12 !== 256) begin errors++; $display("FAIL rate12_wren_rises got %0d want 256", r12); end
    if (unstable !== 0) begin errors++; $display("FAIL rate12_between_ticks got %0d changes want 0", unstable); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    per        = 1;
    rises      = 0;
    unstable   = 0;
    prev_wren  = 1'b0;
    last_addr  = 16'h0000;
    I_reset    = 1'b0;
    I_tick     = 1'b0;
    I_cpu_odd  = 1'b0;
    I_cpu_addr = 16'h0000;
    I_cpu_wren = 1'b0;
    I_cpu_data = 8'h00;
    repeat (3) @(posedge I_clock);
    #1;
    test_reset();
    I_reset = 1'b1;
    @(posedge I_clock);
    #1;
    test_even();
    test_odd();
    test_page_ff();
    test_retrigger();
    test_reset_mid();
    test_tick_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
